// File: rtl/snake_pkg.sv
// snake_pkg -- shared types and helpers for the snake game engine.
//   dir_t   : movement direction (UP, DOWN, LEFT, RIGHT)
//   state_t : step sequencer states (IDLE, CALC, COMMIT, OVER)
//   pos_t   : grid cell {x, y}, sized for the largest supported grid (64x64);
//             smaller grids keep the upper coordinate bits at zero.
package snake_pkg;

    localparam int COORD_W = 6;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2,
        OVER   = 2'd3
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    // Cell (i, 0): the initial snake lies along row 0.
    function automatic pos_t init_pos(input int i);
        pos_t p;
        p.x = COORD_W'(i);
        p.y = '0;
        return p;
    endfunction

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return ((a == UP)   && (b == DOWN))  || ((a == DOWN)  && (b == UP)) ||
               ((a == LEFT) && (b == RIGHT)) || ((a == RIGHT) && (b == LEFT));
    endfunction

    // One step in direction d on a w x h torus.
    function automatic pos_t step_pos(input pos_t p, input dir_t d, input int w, input int h);
        pos_t n;
        n = p;
        case (d)
            UP:      n.y = (p.y == '0) ? COORD_W'(h - 1) : p.y - COORD_W'(1);
            DOWN:    n.y = (p.y == COORD_W'(h - 1)) ? '0 : p.y + COORD_W'(1);
            LEFT:    n.x = (p.x == '0) ? COORD_W'(w - 1) : p.x - COORD_W'(1);
            default: n.x = (p.x == COORD_W'(w - 1)) ? '0 : p.x + COORD_W'(1);
        endcase
        return n;
    endfunction

    function automatic logic in_grid(input pos_t p, input int w, input int h);
        return (int'(p.x) < w) && (int'(p.y) < h);
    endfunction

    // Row-major bitmap index.
    function automatic int cell_idx(input pos_t p, input int w);
        return int'(p.y) * w + int'(p.x);
    endfunction

endpackage

// File: rtl/snake_body_buf.sv
// snake_body_buf -- circular buffer holding the snake body, tail to head.
//   clk, reset    : clock, asynchronous active-low reset
//   init_i        : synchronous re-initialisation to the starting body
//   push_i        : append push_pos_i as the new head entry
//   pop_i         : drop the tail entry (may coincide with push_i)
//   tail_pos_o    : registered copy of the tail entry; it follows a pop one
//                   cycle later, which the engine's IDLE cycle always covers
module snake_body_buf
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic init_i,
    input  logic push_i,
    input  logic pop_i,
    input  pos_t push_pos_i,
    output pos_t tail_pos_o
);

    localparam int PW = $clog2(MAX_LEN);

    pos_t          mem_q [MAX_LEN];
    logic [PW-1:0] head_ptr_q;
    logic [PW-1:0] tail_ptr_q;
    logic [PW-1:0] head_ptr_nxt;
    logic [PW-1:0] tail_ptr_nxt;
    pos_t          tail_pos_q;

    // Depth need not be a power of two, so wrap explicitly.
    assign head_ptr_nxt = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + PW'(1);
    assign tail_ptr_nxt = (tail_ptr_q == PW'(MAX_LEN - 1)) ? '0 : tail_ptr_q + PW'(1);

    // Entries are individual flops so the starting body can be preloaded.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_entry
            localparam pos_t INIT_ENTRY = (gi < INIT_LEN) ? init_pos(gi) : '0;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    mem_q[gi] <= INIT_ENTRY;
                end else if (init_i) begin
                    mem_q[gi] <= INIT_ENTRY;
                end else if (push_i && (head_ptr_nxt == PW'(gi))) begin
                    mem_q[gi] <= push_pos_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr_q <= PW'(INIT_LEN - 1);
            tail_ptr_q <= '0;
            tail_pos_q <= init_pos(0);
        end else if (init_i) begin
            head_ptr_q <= PW'(INIT_LEN - 1);
            tail_ptr_q <= '0;
            tail_pos_q <= init_pos(0);
        end else begin
            if (push_i) head_ptr_q <= head_ptr_nxt;
            if (pop_i)  tail_ptr_q <= tail_ptr_nxt;
            tail_pos_q <= mem_q[tail_ptr_q];
        end
    end

    assign tail_pos_o = tail_pos_q;

endmodule

// File: rtl/snake_engine.sv
// snake_engine -- snake game core: direction control, stepping, growth,
// self-collision detection, food placement and a registered pixel query.
//   clk, reset                    : clock, asynchronous active-low reset
//   tick                          : one-cycle step request (honoured in IDLE)
//   btn_up/down/left/right        : level direction requests
//   restart                       : synchronous re-initialisation
//   food_valid, food_x, food_y    : candidate food cell, taken while food_req
//   food_req                      : no food currently placed
//   rd_x, rd_y -> rd_pix, rd_food : occupancy/food lookup, one cycle latency
//   head_x, head_y, length        : current head cell and snake length
//   busy, ate, game_over          : step in progress, food eaten, dead
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 8,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          restart,
    input  logic          food_valid,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    output logic          food_req,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_pix,
    output logic          rd_food,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          ate,
    output logic          game_over
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL);
    // Starting body occupies cells 0..INIT_LEN-1 of row 0.
    localparam logic [NCELL-1:0] INIT_MAP = {{(NCELL - INIT_LEN){1'b0}}, {INIT_LEN{1'b1}}};

    state_t           state_q,    state_d;
    dir_t             dir_q,      dir_d;
    pos_t             head_q,     head_d;
    pos_t             next_q,     next_d;
    logic             grow_q,     grow_d;
    logic             eat_q,      eat_d;
    logic [LW-1:0]    len_q,      len_d;
    pos_t             food_q,     food_d;
    logic             food_vld_q, food_vld_d;
    logic [NCELL-1:0] map_q,      map_d;
    logic             rd_pix_q,   rd_pix_d;
    logic             rd_food_q,  rd_food_d;

    pos_t tail_pos;
    pos_t step_nxt;
    pos_t pend_head;
    pos_t food_in;
    pos_t rd_pos;
    dir_t btn_dir;
    logic btn_any;
    logic step_eat;
    logic step_grow;
    logic step_hit;
    logic food_ok;
    logic rd_ok;
    logic buf_push;
    logic buf_pop;

    snake_body_buf #(
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN)
    ) u_body (
        .clk        (clk),
        .reset      (reset),
        .init_i     (restart),
        .push_i     (buf_push),
        .pop_i      (buf_pop),
        .push_pos_i (next_q),
        .tail_pos_o (tail_pos)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        head_d     = head_q;
        next_d     = next_q;
        grow_d     = grow_q;
        eat_d      = eat_q;
        len_d      = len_q;
        food_d     = food_q;
        food_vld_d = food_vld_q;
        map_d      = map_q;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;

        // Highest-priority pressed button wins; a reversal is dropped.
        btn_any = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        btn_dir = UP;
        else if (btn_down) btn_dir = DOWN;
        else if (btn_left) btn_dir = LEFT;
        else               btn_dir = RIGHT;

        step_nxt  = step_pos(head_q, dir_q, GRID_W, GRID_H);
        step_eat  = food_vld_q && (step_nxt == food_q);
        step_grow = step_eat && (len_q < LW'(MAX_LEN));
        // The tail cell is vacated in the same commit unless the snake grows.
        step_hit  = map_q[IW'(cell_idx(step_nxt, GRID_W))] &&
                    !(!step_grow && (step_nxt == tail_pos));

        case (state_q)
            IDLE: begin
                if (btn_any && !is_opposite(btn_dir, dir_q)) dir_d = btn_dir;
                if (tick) state_d = CALC;
            end
            CALC: begin
                next_d  = step_nxt;
                grow_d  = step_grow;
                eat_d   = step_eat;
                state_d = step_hit ? OVER : COMMIT;
            end
            COMMIT: begin
                head_d   = next_q;
                buf_push = 1'b1;
                buf_pop  = !grow_q;
                // Clear before set: the new head may land on the old tail.
                if (!grow_q) map_d[IW'(cell_idx(tail_pos, GRID_W))] = 1'b0;
                map_d[IW'(cell_idx(next_q, GRID_W))] = 1'b1;
                if (grow_q) len_d = len_q + LW'(1);
                if (eat_q)  food_vld_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                // OVER: everything frozen until restart.
            end
        endcase

        // Food placement. A cell about to become the head is refused too,
        // otherwise food could end up hidden under the body.
        food_in = '0;
        food_in.x[XW-1:0] = food_x;
        food_in.y[YW-1:0] = food_y;
        pend_head = (state_q == CALC) ? step_nxt : next_q;
        food_ok = 1'b0;
        if (in_grid(food_in, GRID_W, GRID_H)) begin
            food_ok = !map_q[IW'(cell_idx(food_in, GRID_W))] &&
                      !(busy && (food_in == pend_head));
        end
        if (!food_vld_q && food_valid && food_ok) begin
            food_vld_d = 1'b1;
            food_d     = food_in;
        end

        rd_pos = '0;
        rd_pos.x[XW-1:0] = rd_x;
        rd_pos.y[YW-1:0] = rd_y;
        rd_ok     = in_grid(rd_pos, GRID_W, GRID_H);
        rd_pix_d  = 1'b0;
        rd_food_d = 1'b0;
        if (rd_ok) begin
            rd_pix_d  = map_q[IW'(cell_idx(rd_pos, GRID_W))];
            rd_food_d = food_vld_q && (food_q == rd_pos);
        end

        if (restart) begin
            state_d    = IDLE;
            dir_d      = RIGHT;
            head_d     = init_pos(INIT_LEN - 1);
            next_d     = init_pos(INIT_LEN - 1);
            grow_d     = 1'b0;
            eat_d      = 1'b0;
            len_d      = LW'(INIT_LEN);
            food_d     = '0;
            food_vld_d = 1'b0;
            map_d      = INIT_MAP;
            rd_pix_d   = 1'b0;
            rd_food_d  = 1'b0;
            buf_push   = 1'b0;
            buf_pop    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dir_q      <= RIGHT;
            head_q     <= init_pos(INIT_LEN - 1);
            next_q     <= init_pos(INIT_LEN - 1);
            grow_q     <= 1'b0;
            eat_q      <= 1'b0;
            len_q      <= LW'(INIT_LEN);
            food_q     <= '0;
            food_vld_q <= 1'b0;
            map_q      <= INIT_MAP;
            rd_pix_q   <= 1'b0;
            rd_food_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            head_q     <= head_d;
            next_q     <= next_d;
            grow_q     <= grow_d;
            eat_q      <= eat_d;
            len_q      <= len_d;
            food_q     <= food_d;
            food_vld_q <= food_vld_d;
            map_q      <= map_d;
            rd_pix_q   <= rd_pix_d;
            rd_food_q  <= rd_food_d;
        end
    end

    assign food_req  = !food_vld_q;
    assign rd_pix    = rd_pix_q;
    assign rd_food   = rd_food_q;
    assign head_x    = head_q.x[XW-1:0];
    assign head_y    = head_q.y[YW-1:0];
    assign length    = len_q;
    assign busy      = (state_q == CALC) || (state_q == COMMIT);
    assign ate       = (state_q == COMMIT) && eat_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_snake_engine.sv
// Directed testbench for snake_engine (16x8 grid, MAX_LEN 32, INIT_LEN 3).
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       restart = 1'b0;
    logic       food_valid = 1'b0;
    logic [3:0] food_x = '0;
    logic [2:0] food_y = '0;
    logic       food_req;
    logic [3:0] rd_x = '0;
    logic [2:0] rd_y = '0;
    logic       rd_pix, rd_food;
    logic [3:0] head_x;
    logic [2:0] head_y;
    logic [5:0] length;
    logic       busy, ate, game_over;

    int errors  = 0;
    int checks  = 0;
    int ate_cnt = 0;

    always #5 clk = ~clk;

    snake_engine #(
        .GRID_W (16), .GRID_H (8), .MAX_LEN (32), .INIT_LEN (3)
    ) dut (
        .clk (clk), .reset (reset), .tick (tick),
        .btn_up (btn_up), .btn_down (btn_down), .btn_left (btn_left), .btn_right (btn_right),
        .restart (restart), .food_valid (food_valid), .food_x (food_x), .food_y (food_y),
        .food_req (food_req), .rd_x (rd_x), .rd_y (rd_y), .rd_pix (rd_pix), .rd_food (rd_food),
        .head_x (head_x), .head_y (head_y), .length (length),
        .busy (busy), .ate (ate), .game_over (game_over)
    );

    // ---------------- stimulus helpers (no checking except step timeout) ----
    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Tick with the given buttons held for the sampling cycle, then wait for
    // the step to finish; ate pulses seen along the way are counted.
    task automatic do_tick(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        if (ate) ate_cnt++;
        for (int i = 0; i < 8 && busy; i++) begin
            @(negedge clk);
            if (ate) ate_cnt++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL step_timeout busy=%b required=0", busy);
        end
    endtask

    task automatic place_food(input logic [3:0] x, input logic [2:0] y);
        @(negedge clk); food_valid = 1'b1; food_x = x; food_y = y;
        @(negedge clk); food_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [3:0] x, input logic [2:0] y,
                             output logic pix, output logic fd);
        @(negedge clk); rd_x = x; rd_y = y;
        @(negedge clk); pix = rd_pix; fd = rd_food;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic p, f;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({head_x, head_y, length} !== {4'd2, 3'd0, 6'd3}) begin
            errors++;
            $display("FAIL reset_head_len got=(%0d,%0d) len=%0d required=(2,0) len=3", head_x, head_y, length);
        end
        checks++;
        if ({food_req, busy, ate, game_over, rd_pix, rd_food} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got req/busy/ate/over/pix/food=%b%b%b%b%b%b required=100000",
                     food_req, busy, ate, game_over, rd_pix, rd_food);
        end
        reset = 1'b1;
        @(negedge clk);
        read_cell(4'd0, 3'd0, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL reset_pix_0_0 got=%b required=1", p); end
        read_cell(4'd2, 3'd0, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL reset_pix_2_0 got=%b required=1", p); end
        read_cell(4'd3, 3'd0, p, f);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL reset_pix_3_0 got=%b required=0", p); end
        read_cell(4'd0, 3'd1, p, f);
        checks++;
        if ({p, f} !== 2'b00) begin errors++; $display("FAIL reset_pix_0_1 got=%b%b required=00", p, f); end
        $display("test_reset done");
    endtask

    task automatic test_move();
        logic p, f;
        do_reset();
        // First step done by hand to observe the 3-cycle latency.
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy got=%b required=1", busy); end
        @(negedge clk);
        checks++;
        if (head_x !== 4'd2) begin errors++; $display("FAIL latency_early got=%0d required=2", head_x); end
        @(negedge clk);
        checks++;
        if ({head_x, busy} !== {4'd3, 1'b0}) begin
            errors++; $display("FAIL latency_head got=%0d busy=%b required=3 busy=0", head_x, busy);
        end
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 0, 0, 0);
            checks++;
            if ({head_x, head_y} !== {4'(4 + i), 3'd0}) begin
                errors++; $display("FAIL move_head step=%0d got=(%0d,%0d) required=(%0d,0)", i + 2, head_x, head_y, 4 + i);
            end
        end
        checks++;
        if (length !== 6'd3) begin errors++; $display("FAIL move_length got=%0d required=3", length); end
        read_cell(4'd3, 3'd0, p, f);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL move_old_tail got=%b required=0", p); end
        read_cell(4'd4, 3'd0, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL move_tail_4_0 got=%b required=1", p); end
        read_cell(4'd7, 3'd0, p, f);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL move_ahead_7_0 got=%b required=0", p); end
        $display("test_move done");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 13; i++) do_tick(0, 0, 0, 0);
        checks++;
        if ({head_x, head_y} !== {4'd15, 3'd0}) begin
            errors++; $display("FAIL wrap_pre got=(%0d,%0d) required=(15,0)", head_x, head_y);
        end
        do_tick(0, 0, 0, 0);
        checks++;
        if ({head_x, head_y} !== {4'd0, 3'd0}) begin
            errors++; $display("FAIL wrap_x got=(%0d,%0d) required=(0,0)", head_x, head_y);
        end
        do_tick(1, 0, 0, 0);
        checks++;
        if ({head_x, head_y} !== {4'd0, 3'd7}) begin
            errors++; $display("FAIL wrap_y got=(%0d,%0d) required=(0,7)", head_x, head_y);
        end
        $display("test_wrap done");
    endtask

    task automatic test_food();
        logic p, f;
        do_reset();
        place_food(4'd4, 3'd0);
        checks++;
        if (food_req !== 1'b0) begin errors++; $display("FAIL food_placed_req got=%b required=0", food_req); end
        read_cell(4'd4, 3'd0, p, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL food_rd_food got=%b required=1", f); end
        ate_cnt = 0;
        do_tick(0, 0, 0, 0);
        do_tick(0, 0, 0, 0);
        checks++;
        if (ate_cnt !== 1) begin errors++; $display("FAIL food_ate_pulses got=%0d required=1", ate_cnt); end
        checks++;
        if ({head_x, length, food_req} !== {4'd4, 6'd4, 1'b1}) begin
            errors++; $display("FAIL food_after got head_x=%0d len=%0d req=%b required 4 4 1", head_x, length, food_req);
        end
        read_cell(4'd1, 3'd0, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL food_tail_kept got=%b required=1", p); end
        read_cell(4'd4, 3'd0, p, f);
        checks++;
        if ({p, f} !== 2'b10) begin errors++; $display("FAIL food_eaten_cell got=%b%b required=10", p, f); end
        $display("test_food done");
    endtask

    task automatic test_over();
        logic p, f;
        do_reset();
        place_food(4'd3, 3'd0);
        do_tick(0, 0, 1, 0);   // left while moving right: ignored
        checks++;
        if ({head_x, head_y, length} !== {4'd3, 3'd0, 6'd4}) begin
            errors++; $display("FAIL over_left_ignored got=(%0d,%0d) len=%0d required=(3,0) len=4", head_x, head_y, length);
        end
        place_food(4'd4, 3'd0);
        do_tick(0, 0, 0, 0);
        do_tick(1, 0, 0, 0);
        do_tick(0, 0, 1, 0);
        checks++;
        if ({head_x, head_y, length, game_over} !== {4'd3, 3'd7, 6'd5, 1'b0}) begin
            errors++; $display("FAIL over_path got=(%0d,%0d) len=%0d over=%b required=(3,7) len=5 over=0",
                               head_x, head_y, length, game_over);
        end
        do_tick(0, 1, 0, 0);   // down into (3,0): body
        checks++;
        if ({game_over, head_x, head_y, length} !== {1'b1, 4'd3, 3'd7, 6'd5}) begin
            errors++; $display("FAIL over_collide over=%b got=(%0d,%0d) len=%0d required over=1 (3,7) len=5",
                               game_over, head_x, head_y, length);
        end
        do_tick(0, 0, 0, 0);
        checks++;
        if ({game_over, head_x, head_y} !== {1'b1, 4'd3, 3'd7}) begin
            errors++; $display("FAIL over_frozen over=%b got=(%0d,%0d) required over=1 (3,7)", game_over, head_x, head_y);
        end
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        checks++;
        if ({game_over, head_x, head_y, length, food_req, busy} !== {1'b0, 4'd2, 3'd0, 6'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL restart_state over=%b got=(%0d,%0d) len=%0d req=%b busy=%b required 0 (2,0) 3 1 0",
                               game_over, head_x, head_y, length, food_req, busy);
        end
        read_cell(4'd4, 3'd7, p, f);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL restart_map_4_7 got=%b required=0", p); end
        read_cell(4'd1, 3'd0, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL restart_map_1_0 got=%b required=1", p); end
        do_tick(0, 0, 0, 0);
        checks++;
        if ({head_x, head_y} !== {4'd3, 3'd0}) begin
            errors++; $display("FAIL restart_step got=(%0d,%0d) required=(3,0)", head_x, head_y);
        end
        $display("test_over done");
    endtask

    task automatic test_drop_busy();
        logic p, f;
        do_reset();
        place_food(4'd1, 3'd0);
        checks++;
        if (food_req !== 1'b1) begin errors++; $display("FAIL drop_req got=%b required=1", food_req); end
        read_cell(4'd1, 3'd0, p, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL drop_rd_food got=%b required=0", f); end
        // Hold tick through IDLE, CALC and COMMIT: only one step may happen.
        @(negedge clk); tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({head_x, head_y} !== {4'd3, 3'd0}) begin
            errors++; $display("FAIL busy_one_step got=(%0d,%0d) required=(3,0)", head_x, head_y);
        end
        place_food(4'd9, 3'd5);
        checks++;
        if (food_req !== 1'b0) begin errors++; $display("FAIL place_free_req got=%b required=0", food_req); end
        place_food(4'd10, 3'd5);   // already has food: ignored
        read_cell(4'd9, 3'd5, p, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL food_kept_9_5 got=%b required=1", f); end
        read_cell(4'd10, 3'd5, p, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL food_ignored_10_5 got=%b required=0", f); end
        $display("test_drop_busy done");
    endtask

    task automatic test_reset_mid_step();
        logic p, f;
        do_reset();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); reset = 1'b0;   // in COMMIT
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({head_x, head_y, length, busy} !== {4'd2, 3'd0, 6'd3, 1'b0}) begin
            errors++; $display("FAIL midreset_state got=(%0d,%0d) len=%0d busy=%b required=(2,0) 3 0",
                               head_x, head_y, length, busy);
        end
        read_cell(4'd3, 3'd0, p, f);
        checks++;
        if (p !== 1'b0) begin errors++; $display("FAIL midreset_no_push got=%b required=0", p); end
        read_cell(4'd0, 3'd0, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL midreset_no_pop got=%b required=1", p); end
        $display("test_reset_mid_step done");
    endtask

    initial begin
        test_reset();
        test_move();
        test_wrap();
        test_food();
        test_over();
        test_drop_busy();
        test_reset_mid_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
